csla_rr_arbiter: RTL and testbench
==================================

// Module: csla_rr_arbiter
// PURPOSE
//  Shares one 16-bit square-root carry-select adder (sqrt_csla) between NREQ requesters.
//  Round-robin arbitration with valid/ready handshakes on every requester and on the result port.
//  Supports multi-beat "chained" adds: carry-out of one beat feeds carry-in of the next, grant locked.
//  Sits between the AXI-side operand producers and the result consumers; one result register stage.
// PARAMETERS
//  WIDTH  16  operand/sum width passed to sqrt_csla (16 selects its optimised structure)
//  NREQ   4   number of requesters, 2..16
//  IDW    localparam = $clog2(NREQ); width of rsp_id
// PORTS
//  ACLK       in   1           clock, all state on rising edge
//  ARESETn    in   1           asynchronous active-low reset
//  req_valid  in   NREQ        per-requester operand valid
//  req_ready  out  NREQ        per-requester accept; at most one bit high per cycle
//  req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand B, same packing
//  req_cin    in   NREQ        carry-in; ignored on chained continuation beats
//  req_chain  in   NREQ        1 = more beats follow; lock grant, forward cout as next cin
//  rsp_valid  out  1           result register holds a result
//  rsp_ready  in   1           consumer accept
//  rsp_sum    out  WIDTH       registered sum
//  rsp_cout   out  1           registered carry-out
//  rsp_id     out  IDW         index of requester that produced the result
//  rsp_last   out  1           1 = final beat of operation (chain was 0)
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_last=0, ptr=0, state=ARB, carry_q=0.
//  req_ready is combinational from req_valid/state/ptr/rsp_valid/rsp_ready; all 0 during reset.
//  can_load = !rsp_valid || rsp_ready. If !can_load: all req_ready=0, no state change.
//  ARB: grant = first i with req_valid[i], searching ptr, ptr+1, .. wrapping mod NREQ.
//   req_ready[grant]=can_load. Accept = valid&ready. Adder cin = req_cin[grant].
//  LOCKED(owner): only owner considered; req_ready[owner]=can_load; others 0 even if valid.
//   Adder cin = carry_q (registered cout of previous beat); req_cin ignored.
//  On accept: rsp_{sum,cout} <= adder out, rsp_id <= grant, rsp_last <= !req_chain[grant],
//   rsp_valid <= 1, carry_q <= adder cout.
//   chain=1 -> state LOCKED, owner=grant, ptr unchanged.
//   chain=0 -> state ARB, ptr <= (grant+1) mod NREQ (wrap NREQ-1 -> 0).
//  No accept and rsp_ready -> rsp_valid <= 0. Simultaneous consume+load: new result replaces, valid stays 1.
//  Latency: accept in cycle N -> rsp_valid in N+1. Throughput 1 beat/cycle with rsp_ready held 1.
//  LOCKED owner dropping req_valid: arbiter waits, stays LOCKED (no timeout); others starve.
//  No valid requesters: nothing accepted, ptr holds.
//  ARESETn low mid-chain: immediate return to reset values, lock and carry_q discarded.
//  rsp outputs hold stable while rsp_valid && !rsp_ready.
// STRUCTURE
//  Shared package csla_pkg: state encoding (ST_ARB, ST_LOCKED), clog2 helper, default WIDTH/NREQ.
//  Sub-module rr_priority_picker (NREQ-wide rotate-by-ptr, find-first, one-hot + index out).
//  One sqrt_csla #(WIDTH) instance on the muxed operands; top holds FSM, ptr, carry_q, result reg.
// TESTING
//  1 Single req0 a=16'h1234 b=16'h0FF0 cin=0 chain=0 -> next cycle rsp_sum=16'h2224, cout=0, id=0, last=1.
//  2 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; ptr wraps 3->0.
//  3 req2 chain: beat1 a=FFFF b=0001 chain=1, beat2 a=0000 b=0000 cin=0 chain=0 -> sums 0000/cout1, 0001/cout0; req1 valid throughout gets no ready until after beat2.
//  4 rsp_ready=0 for 3 cycles with result held -> req_ready all 0, rsp_sum/id stable; release -> next grant same cycle.
//  5 ARESETn asserted between chain beats -> rsp_valid=0, ptr=0, state ARB; after release req0 granted first, carry_q not used.
//  6 a=FFFF b=FFFF cin=1 -> rsp_sum=FFFF, rsp_cout=1 (full-carry path through all groups).

Source files
------------

// File: rtl/csla_pkg.sv
// Shared definitions for the carry-select-adder arbiter: state encoding, defaults,
// and elaboration-time helpers describing the square-root group layout.
package csla_pkg;

    localparam int CSLA_WIDTH = 16;
    localparam int CSLA_NREQ  = 4;
    localparam int CSLA_NGRP  = 5;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Never returns less than 1 so index buses stay at least one bit wide.
    function automatic int csla_clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Group widths grow 2,2,3,4,5 so each mux select arrives as its group sums settle.
    function automatic int csla_grp_w(input int g);
        case (g)
            0, 1:    return 2;
            2:       return 3;
            3:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int csla_grp_lo(input int g);
        int lo;
        lo = 0;
        for (int k = 0; k < g; k++) begin
            lo += csla_grp_w(k);
        end
        return lo;
    endfunction

endpackage

// File: rtl/csla_rr_arbiter_adder.sv
// Square-root carry-select adder; at 16 bits each group precomputes both carry cases
// and the incoming group carry only drives a mux.
module sqrt_csla
    import csla_pkg::*;
#(
    parameter int WIDTH = CSLA_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    generate
        if (WIDTH == 16) begin : g_sqrt
            logic [CSLA_NGRP:0] w_c;

            assign w_c[0] = i_cin;

            for (genvar gi = 0; gi < CSLA_NGRP; gi++) begin : g_grp
                localparam int LO = csla_grp_lo(gi);
                localparam int GW = csla_grp_w(gi);
                logic [GW:0] w_s0;
                logic [GW:0] w_s1;

                assign w_s0 = {1'b0, i_a[LO +: GW]} + {1'b0, i_b[LO +: GW]};
                assign w_s1 = w_s0 + (GW + 1)'(1);
                assign o_sum[LO +: GW] = w_c[gi] ? w_s1[GW-1:0] : w_s0[GW-1:0];
                assign w_c[gi+1]       = w_c[gi] ? w_s1[GW] : w_s0[GW];
            end

            assign o_cout = w_c[CSLA_NGRP];
        end else begin : g_plain
            assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
        end
    endgenerate

endmodule

// File: rtl/csla_rr_arbiter_picker.sv
// Rotating priority picker: first asserted request at or after i_ptr, wrapping,
// reported both as an index and as a one-hot vector.
module rr_priority_picker
    import csla_pkg::*;
#(
    parameter int NREQ = CSLA_NREQ,
    parameter int IDW  = csla_clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW:0]      w_off;
    logic [IDW:0]      w_sum;

    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NREQ-1:0];
    assign o_any = |i_req;

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (IDW + 1)'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (IDW + 1)'(NREQ)) begin
            w_sum = w_sum - (IDW + 1)'(NREQ);
        end
        o_idx    = w_sum[IDW-1:0];
        o_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (o_any && (o_idx == IDW'(k))) begin
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csla_rr_arbiter.sv
// Round-robin front end sharing one carry-select adder among NREQ requesters, with
// grant locking for chained multi-beat adds and a single registered result stage.
module csla_rr_arbiter
    import csla_pkg::*;
#(
    parameter int  WIDTH = CSLA_WIDTH,
    parameter int  NREQ  = CSLA_NREQ,
    localparam int IDW   = csla_clog2(NREQ)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_chain,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_last
);

    arb_state_e       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_owner;
    logic             r_carry;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_last;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [IDW-1:0]   w_pick_idx;
    logic             w_pick_any;
    logic             w_locked;
    logic [IDW-1:0]   w_grant;
    logic [NREQ-1:0]  w_owner_oh;
    logic [NREQ-1:0]  w_grant_oh;
    logic             w_can_load;
    logic             w_offer;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_sel_cin;
    logic             w_sel_chain;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [IDW-1:0]   w_ptr_next;

    rr_priority_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_locked   = (r_state == ST_LOCKED);
    assign w_grant    = w_locked ? r_owner : w_pick_idx;
    assign w_can_load = !r_rsp_valid || rsp_ready;

    always_comb begin
        w_owner_oh  = '0;
        w_op_a      = '0;
        w_op_b      = '0;
        w_sel_cin   = 1'b0;
        w_sel_chain = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDW'(i)) begin
                w_owner_oh[i] = 1'b1;
            end
            if (w_grant == IDW'(i)) begin
                w_op_a      = req_a[i*WIDTH +: WIDTH];
                w_op_b      = req_b[i*WIDTH +: WIDTH];
                w_sel_cin   = req_cin[i];
                w_sel_chain = req_chain[i];
            end
        end
    end

    // A locked owner is offered ready even while idle, so its next beat lands immediately.
    assign w_grant_oh = w_locked ? w_owner_oh : w_pick_onehot;
    assign w_offer    = w_can_load && (w_locked || w_pick_any);
    assign req_ready  = (ARESETn && w_offer) ? w_grant_oh : '0;
    assign w_accept   = |(req_ready & req_valid);
    assign w_cin      = w_locked ? r_carry : w_sel_cin;
    assign w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

    sqrt_csla #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= ST_ARB;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_last  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_id    <= w_grant;
            r_rsp_last  <= !w_sel_chain;
            r_carry     <= w_cout;
            if (w_sel_chain) begin
                r_state <= ST_LOCKED;
                r_owner <= w_grant;
            end else begin
                r_state <= ST_ARB;
                r_ptr   <= w_ptr_next;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_csla_rr_arbiter.sv
// Bench for csla_rr_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_csla_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [1:0]        rsp_id;
    logic              rsp_last;

    always #5 clk = ~clk;

    csla_rr_arbiter #(
        .WIDTH (W),
        .NREQ  (NREQ)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
    );

    // ---------------- behavioural model ----------------
    logic        m_rv     = 1'b0;
    logic [15:0] m_sum    = '0;
    logic        m_cout   = 1'b0;
    int          m_id     = 0;
    logic        m_last   = 1'b0;
    int          m_ptr    = 0;
    logic        m_locked = 1'b0;
    int          m_owner  = 0;
    logic        m_carry  = 1'b0;

    function automatic int m_grant();
        if (m_locked) return m_owner;
        for (int i = 0; i < NREQ; i++) begin
            automatic int j = (m_ptr + i) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic int m_ready();
        automatic int g = m_grant();
        if (!rst_n || g < 0 || !(!m_rv || rsp_ready)) return 0;
        return 1 << g;
    endfunction

    function automatic logic m_accept();
        automatic int g = m_grant();
        return rst_n && (g >= 0) && (!m_rv || rsp_ready) && req_valid[g];
    endfunction

    function automatic logic [16:0] m_add(input int g);
        automatic logic c = m_locked ? m_carry : req_cin[g];
        return {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + {16'd0, c};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rv     <= 1'b0;
            m_sum    <= '0;
            m_cout   <= 1'b0;
            m_id     <= 0;
            m_last   <= 1'b0;
            m_ptr    <= 0;
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_carry  <= 1'b0;
        end else if (m_accept()) begin
            m_rv             <= 1'b1;
            {m_cout, m_sum}  <= m_add(m_grant());
            m_carry          <= (m_add(m_grant()) > 17'h0FFFF);
            m_id             <= m_grant();
            m_last           <= !req_chain[m_grant()];
            if (req_chain[m_grant()]) begin
                m_locked <= 1'b1;
                m_owner  <= m_grant();
            end else begin
                m_locked <= 1'b0;
                m_ptr    <= (m_grant() + 1) % NREQ;
            end
        end else if (rsp_ready) begin
            m_rv <= 1'b0;
        end
    end

    // ---------------- comparison process ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic        lit_en = 1'b0;
    logic        lit_data = 1'b0;
    logic [15:0] lit_sum = '0;
    logic        lit_cout = 1'b0;
    int          lit_id = 0;
    logic        lit_last = 1'b0;
    logic        lit_rdy_en = 1'b0;
    int          lit_rdy = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        chk("req_ready", int'(req_ready), m_ready());
        chk("rsp_valid", int'(rsp_valid), rst_n ? int'(m_rv) : 0);
        chk("rsp_sum",   int'(rsp_sum),   rst_n ? int'(m_sum) : 0);
        chk("rsp_cout",  int'(rsp_cout),  rst_n ? int'(m_cout) : 0);
        chk("rsp_id",    int'(rsp_id),    rst_n ? m_id : 0);
        chk("rsp_last",  int'(rsp_last),  rst_n ? int'(m_last) : 0);
        if (lit_en) begin
            chk("lit_valid", int'(rsp_valid), 1);
            chk("lit_id",    int'(rsp_id),    lit_id);
            if (lit_data) begin
                chk("lit_sum",  int'(rsp_sum),  int'(lit_sum));
                chk("lit_cout", int'(rsp_cout), int'(lit_cout));
                chk("lit_last", int'(rsp_last), int'(lit_last));
            end
        end
        if (lit_rdy_en) begin
            chk("lit_ready", int'(req_ready), lit_rdy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        req_valid  = '0;
        req_chain  = '0;
        req_cin    = '0;
        lit_en     = 1'b0;
        lit_rdy_en = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic chain);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_cin[i]       = cin;
        req_chain[i]     = chain;
    endtask

    task automatic lit_rsp(input logic [15:0] s, input logic c, input int id, input logic last);
        lit_en   = 1'b1;
        lit_data = 1'b1;
        lit_sum  = s;
        lit_cout = c;
        lit_id   = id;
        lit_last = last;
    endtask

    task automatic lit_id_only(input int id);
        lit_en   = 1'b1;
        lit_data = 1'b0;
        lit_id   = id;
    endtask

    task automatic lit_ready(input int r);
        lit_rdy_en = 1'b1;
        lit_rdy    = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single add, then full-carry add, then a single beat that moves ptr to 2.
        @(negedge clk); idle(); set_req(0, 16'h1234, 16'h0FF0, 1'b0, 1'b0);
        @(negedge clk); idle(); lit_rsp(16'h2224, 1'b0, 0, 1'b1);
        set_req(3, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk); idle(); lit_rsp(16'hFFFF, 1'b1, 3, 1'b1);
        set_req(1, 16'h0001, 16'h0001, 1'b0, 1'b0);

        // Chained add on requester 2 while requester 1 keeps asking.
        @(negedge clk); idle(); lit_rsp(16'h0002, 1'b0, 1, 1'b1);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        set_req(1, 16'h0005, 16'h0005, 1'b0, 1'b0);
        lit_ready(4'b0100);
        @(negedge clk); idle(); lit_rsp(16'h0000, 1'b1, 2, 1'b0);
        set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        set_req(1, 16'h0005, 16'h0005, 1'b0, 1'b0);
        lit_ready(4'b0100);
        @(negedge clk); idle(); lit_rsp(16'h0001, 1'b0, 2, 1'b1);
        set_req(1, 16'h0005, 16'h0005, 1'b0, 1'b0);
        lit_ready(4'b0010);
        @(negedge clk); idle(); lit_rsp(16'h000A, 1'b0, 1, 1'b1);
        set_req(0, 16'h0101, 16'h0202, 1'b0, 1'b0);

        // Back-pressure: result must hold and no requester may be offered ready.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); rsp_ready = 1'b0;
            set_req(0, 16'h0101, 16'h0202, 1'b0, 1'b0);
            set_req(3, 16'h0010, 16'h0020, 1'b0, 1'b0);
            lit_rsp(16'h0303, 1'b0, 0, 1'b1);
            lit_ready(0);
        end
        @(negedge clk); idle(); rsp_ready = 1'b1;
        set_req(0, 16'h0101, 16'h0202, 1'b0, 1'b0);
        set_req(3, 16'h0010, 16'h0020, 1'b0, 1'b0);
        lit_rsp(16'h0303, 1'b0, 0, 1'b1);
        lit_ready(4'b1000);
        @(negedge clk); idle(); lit_rsp(16'h0030, 1'b0, 3, 1'b1);

        // Round robin with everyone valid: grants 0,1,2,3,0,...
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); idle();
            for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
            if (k > 0) lit_id_only((k - 1) % NREQ);
        end
        @(negedge clk); idle(); lit_id_only(0);

        // Reset between chain beats discards lock and carry.
        @(negedge clk); idle(); set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk); idle(); lit_rsp(16'h0000, 1'b1, 2, 1'b0);
        do_reset();
        @(negedge clk); idle();
        set_req(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
        set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk); idle(); lit_rsp(16'h0002, 1'b0, 0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); idle();
            rst_n     = ($urandom_range(0, 299) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_req(i,
                            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                            1'($urandom_range(0, 1)),
                            ($urandom_range(0, 9) < 3));
                end
            end
        end

        @(negedge clk); idle(); rst_n = 1'b1; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
